// File: rtl/retire_halt_dumper.sv
// rtl/retire_halt_dumper.sv - end-of-run halt detector that dumps a data-memory window on a valid/ready stream
// Optional retired-instruction counter: define RETIRE_COUNT_EN.
module retire_halt_dumper #(
  parameter logic [31:0] HALT_PC        = 32'h0000009c,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
  parameter logic [31:0] DUMP_BASE      = 32'd0,
  parameter logic [31:0] DUMP_WORDS     = 32'd1000,
  parameter int          ADDR_W         = 15,
  parameter int          DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ret_valid,
  input  logic [31:0]       ret_pc,
  input  logic [DATA_W-1:0] ret_wb_data,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [DATA_W-1:0] final_wb,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retire_count
);

  typedef enum logic [2:0] {
    S_RUN,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam int          NBYTES       = DATA_W / 8;
  localparam logic [31:0] LAST_IDX     = (DUMP_WORDS == 32'd0) ? 32'd0 : DUMP_WORDS - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] CNT_MAX      = 32'hffff_ffff;

  state_t            state;
  state_t            state_next;
  logic [31:0]       idx;
  logic [31:0]       word_idx;
  logic              pc_hit;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata_rev;

  assign word_idx    = DUMP_BASE + idx;
  assign pc_hit      = ret_valid && (ret_pc == HALT_PC);
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cycle_count == TIMEOUT_LAST);

  // Display order: lowest-addressed byte ends up in the MSBs.
  always_comb begin
    rdata_rev = '0;
    for (int b = 0; b < NBYTES; b++) begin
      rdata_rev[8*(NBYTES-1-b) +: 8] = mem_rdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    mem_addr   = '0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state)
      S_RUN: begin
        if (pc_hit || timeout_hit) begin
          state_next = (DUMP_WORDS == 32'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_re     = 1'b1;
        mem_addr   = ADDR_W'(word_idx);
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          state_next = (idx == LAST_IDX) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      cycle_count <= '0;
      halt_cause  <= 2'b00;
      final_wb    <= '0;
      dump_data   <= '0;
      dump_addr   <= '0;
    end else begin
      if (state == S_RUN) begin
        if (cycle_count != CNT_MAX) begin
          cycle_count <= cycle_count + 32'd1;
        end
        // A PC hit wins over a coincident timeout.
        if (pc_hit) begin
          final_wb   <= ret_wb_data;
          halt_cause <= 2'b01;
        end else if (timeout_hit) begin
          final_wb   <= '0;
          halt_cause <= 2'b10;
        end
      end
      if (state == S_CAPTURE) begin
        dump_data <= rdata_rev;
        dump_addr <= {word_idx[29:0], 2'b00};
      end
      if ((state == S_PRESENT) && dump_ready && (idx != LAST_IDX)) begin
        idx <= idx + 32'd1;
      end
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if ((state == S_RUN) && ret_valid && (retire_count != CNT_MAX)) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`else
  assign retire_count = '0;
`endif

endmodule

// File: doc/retire_halt_dumper.md
Name: retire_halt_dumper

Overview:
- Synthesizable end-of-run monitor for the pipelined RISC-V core.
- Watches the retire stream for a parametrised halt PC, with a cycle-timeout fallback.
- On halt, captures the final write-back value, walks a window of data memory through a read port, and streams each word out on a valid/ready channel.
- Used in simulation benches and on FPGA to report results without hierarchical peeking.

Parameters:
HALT_PC, 32'h0000009c, retire PC that ends the run
TIMEOUT_CYCLES, 32'd4000000, cycles in RUN before forced halt; 0 disables the timeout
DUMP_BASE, 0, first word index dumped
DUMP_WORDS, 1000, number of words dumped; 0 allowed
ADDR_W, 15, word-address width of the memory read port
DATA_W, 32, data word width; multiple of 8

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ret_valid  in  1  instruction retired this cycle
ret_pc  in  32  PC of the retiring instruction
ret_wb_data  in  DATA_W  write-back value of the retiring instruction
mem_re  out  1  memory read strobe
mem_addr  out  ADDR_W  word address
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_addr  out  32  byte address of dump word = 4*(DUMP_BASE+idx)
dump_data  out  DATA_W  word, byte-reversed (byte 0 in MSBs, display order)
done  out  1  dump complete, sticky
halt_cause  out  2  00 running, 01 PC hit, 10 timeout
final_wb  out  DATA_W  ret_wb_data captured at halt (0 on timeout)
cycle_count  out  32  cycles spent in RUN
retire_count  out  32  retired instructions (see Optional Feature)

Behaviour:
- Reset, asynchronous, active-low: state RUN, idx 0, all outputs 0.
- States: RUN, FETCH, CAPTURE, PRESENT, DONE.
- RUN:
  - cycle_count increments every cycle and saturates at 2^32-1.
  - If ret_valid and ret_pc==HALT_PC: final_wb<=ret_wb_data, halt_cause<=01, next FETCH.
  - Else if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1: halt_cause<=10, final_wb<=0, next FETCH.
  - A PC hit in the same cycle as the timeout gives cause 01.
  - If DUMP_WORDS==0, the next state is DONE instead of FETCH.
- FETCH: mem_re=1 for exactly this cycle, mem_addr=DUMP_BASE+idx (truncated to ADDR_W, wraps modulo 2^ADDR_W); next CAPTURE.
- CAPTURE: dump_data<=byte-reverse(mem_rdata), dump_addr<=4*(DUMP_BASE+idx); next PRESENT.
- PRESENT:
  - dump_valid=1; dump_data and dump_addr stay stable until handshake.
  - On dump_valid&&dump_ready: if idx==DUMP_WORDS-1, next DONE; else idx++, next FETCH.
  - dump_valid must never drop without a handshake.
  - Throughput is 1 word per 3 cycles with dump_ready held high.
- DONE: done=1; dump_valid=0; mem_re=0. Held until reset.
- After leaving RUN: retire inputs ignored; cycle_count and halt_cause frozen.
- mem_re is 0 outside FETCH.
- Reset asserted mid-dump aborts immediately, with no partial handshake.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined:
  - retire_count increments on each ret_valid in RUN, including the halting instruction, and saturates at 2^32-1.
  - Freezes on leaving RUN.
- Undefined: no counter logic; retire_count is tied to 0.

Test Plan:
- Retire pcs 0x0,0x4,…, then 0x9c with ret_wb_data=0x12345678; DUMP_WORDS=4; memory words 0..3 = 0x11223344,…; dump_ready=1 -> halt_cause=01, final_wb=0x12345678; four handshakes, the first with dump_addr=0 and dump_data=0x44332211, the last with dump_addr=0xC; done after the 4th.
- Same run, dump_ready toggling 1-0-0-1 -> dump_valid, dump_data and dump_addr stable across stalls; no word lost or repeated; mem_re pulses exactly 4 times.
- No halt PC, TIMEOUT_CYCLES=100 -> halt_cause=10 with cycle_count=100 and final_wb=0; dump proceeds normally.
- ret_pc==HALT_PC on the same cycle as timeout expiry -> halt_cause=01.
- DUMP_WORDS=0 -> done one cycle after the halt; dump_valid and mem_re are never asserted.
- reset_n low during word 2 of the dump -> all outputs 0 immediately; after release the block re-enters RUN and a new halt restarts the dump from idx 0; with RETIRE_COUNT_EN, 10 retires before halt -> retire_count=10.
